// File: rtl/fpa_rr_scheduler.sv
// rtl/fpa_rr_scheduler.sv - round-robin scheduler sharing one multi-cycle FP adder among N_REQ requesters
// Optional adder-done timeout abort enabled by defining FPA_SCHED_TIMEOUT_EN.
module fpa_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_result,
    output logic               rsp_ovf,
    output logic               rsp_err,
    output logic               fpa_start,
    output logic [W-1:0]       fpa_a,
    output logic [W-1:0]       fpa_b,
    input  logic               fpa_done,
    input  logic [W-1:0]       fpa_result,
    input  logic               fpa_ovf,
    output logic               busy,
    output logic [2:0]         grant_id
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t         state_q, state_d;
    logic [2:0]     ptr_q, ptr_d, grant_q, grant_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic           ovf_q, ovf_d;

    logic [7:0]     valid_pad;
    logic [3:0]     cand;
    logic           found;
    logic [2:0]     win;
    logic [W-1:0]   win_a, win_b;
    logic           in_resp;

`ifdef FPA_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           timeout;
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));
`else
    logic           unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Search upward from ptr, wrapping modulo N_REQ; first valid requester wins.
    always_comb begin
        valid_pad = 8'(req_valid);
        found     = 1'b0;
        win       = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
            if (!found && valid_pad[cand[2:0]]) begin
                found = 1'b1;
                win   = cand[2:0];
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == 3'(i)) begin
                win_a = req_a[i*W +: W];
                win_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
`ifdef FPA_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = win_a;
                    b_d     = win_b;
                    grant_d = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef FPA_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // A done coinciding with the timeout cycle still yields a normal response.
                if (fpa_done) begin
                    res_d   = fpa_result;
                    ovf_d   = fpa_ovf;
                    state_d = RESP;
`ifdef FPA_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
`ifdef FPA_SCHED_TIMEOUT_EN
                else if (timeout) begin
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                ptr_d   = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef FPA_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
`ifdef FPA_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign in_resp    = (state_q == RESP);
    assign req_ready  = (state_q == IDLE && found) ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;
    assign rsp_valid  = in_resp ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign rsp_result = in_resp ? res_q : '0;
    assign rsp_ovf    = in_resp & ovf_q;
`ifdef FPA_SCHED_TIMEOUT_EN
    assign rsp_err    = in_resp & err_q;
`else
    assign rsp_err    = 1'b0;
`endif
    assign fpa_start  = (state_q == ISSUE);
    assign fpa_a      = a_q;
    assign fpa_b      = b_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_fpa_rr_scheduler.sv
// tb/tb_fpa_rr_scheduler.sv - self-checking bench for fpa_rr_scheduler with transaction-level model
// Timeout scenarios run only when FPA_SCHED_TIMEOUT_EN is defined.
module tb_fpa_rr_scheduler;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   req_valid, req_ready, rsp_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   rsp_result, fpa_a, fpa_b, fpa_result;
    logic           rsp_ovf, rsp_err, fpa_start, fpa_done, fpa_ovf, busy;
    logic [2:0]     grant_id;

    fpa_rr_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .fpa_start(fpa_start), .fpa_a(fpa_a), .fpa_b(fpa_b),
        .fpa_done(fpa_done), .fpa_result(fpa_result), .fpa_ovf(fpa_ovf),
        .busy(busy), .grant_id(grant_id)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Requesters: remaining request count each; adder environment model.
    int         rem [N];
    int         add_lat = 5;
    bit         add_hang = 0;
    bit         add_pend = 0;
    int         add_done_cyc = 0;
    logic [W-1:0] add_res;
    logic       add_ovf;
    int         spur_cyc = -1;
    bit         hs_flag = 0;
    int         hs_id = 0;
    int         last_start = 0;

    // Scheduler model state: one transaction in flight, rr pointer, last grant.
    int           m_ptr = 0, m_id = 0, m_start = 0, m_rsp_at = -1;
    bit           m_busy = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic         m_ovf = 1'b0, m_err = 1'b0;

    int           rsp_id_q[$], rsp_cyc_q[$], hs_cyc_q[$];
    logic [W-1:0] rsp_res_q[$];
    logic         rsp_ovf_q[$], rsp_err_q[$];
    logic [N-1:0] rsp_vec_q[$], hs_rdy_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W:0] adder_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return {1'b0, 32'h4040_0000};
        if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {1'b1, 32'h7F80_0000};
        return {1'b0, a ^ b ^ 32'h5A5A_0000};
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy, exp_rsp;
        int pick, rid;
        if (fpa_start) begin
            last_start = cyc;
            if (!add_hang) begin
                {add_ovf, add_res} = adder_fn(fpa_a, fpa_b);
                add_pend = 1;
                add_done_cyc = cyc + add_lat;
            end
        end
        if (rsp_valid != '0) begin
            rid = -1;
            for (int i = 0; i < N; i++) if (rsp_valid[i]) rid = i;
            rsp_id_q.push_back(rid);
            rsp_cyc_q.push_back(cyc);
            rsp_res_q.push_back(rsp_result);
            rsp_ovf_q.push_back(rsp_ovf);
            rsp_err_q.push_back(rsp_err);
            rsp_vec_q.push_back(rsp_valid);
        end
        if (reset) begin
            m_ptr = 0; m_busy = 0; m_id = 0; m_a = '0; m_b = '0; m_rsp_at = -1; hs_flag = 0;
        end else begin
            exp_rdy = '0;
            pick = -1;
            if (!m_busy)
                for (int k = 0; k < N; k++)
                    if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            if (pick >= 0) exp_rdy[pick] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            check("busy", busy, m_busy);
            check("grant_id", grant_id, m_id);
            check("fpa_a", fpa_a, m_a);
            check("fpa_b", fpa_b, m_b);
            check("fpa_start", fpa_start, (m_busy && cyc == m_start));
            exp_rsp = '0;
            if (m_busy && cyc == m_rsp_at) exp_rsp[m_id] = 1'b1;
            check("rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp != '0) begin
                check("rsp_result", rsp_result, m_res);
                check("rsp_ovf", rsp_ovf, m_ovf);
                check("rsp_err", rsp_err, m_err);
                m_busy = 0;
                m_ptr = (m_id + 1) % N;
            end else if (m_busy && m_rsp_at < 0 && cyc > m_start) begin
                if (fpa_done) begin
                    m_rsp_at = cyc + 1; m_res = fpa_result; m_ovf = fpa_ovf; m_err = 1'b0;
                end
`ifdef FPA_SCHED_TIMEOUT_EN
                else if (cyc - m_start == TO) begin
                    m_rsp_at = cyc + 1; m_res = '0; m_ovf = 1'b0; m_err = 1'b1;
                end
`endif
            end
            if (pick >= 0) begin
                m_busy = 1; m_id = pick; m_start = cyc + 1; m_rsp_at = -1;
                m_a = req_a[pick*W +: W];
                m_b = req_b[pick*W +: W];
                hs_flag = 1; hs_id = pick;
                hs_cyc_q.push_back(cyc);
                hs_rdy_q.push_back(req_ready);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (hs_flag) begin rem[hs_id]--; hs_flag = 0; end
        for (int i = 0; i < N; i++) req_valid[i] = (rem[i] > 0);
        if (add_pend && cyc == add_done_cyc) begin
            fpa_done = 1'b1; fpa_result = add_res; fpa_ovf = add_ovf; add_pend = 0;
        end else if (cyc == spur_cyc) begin
            fpa_done = 1'b1; fpa_result = 32'hDEAD_BEEF; fpa_ovf = 1'b1;
        end else begin
            fpa_done = 1'b0; fpa_result = '0; fpa_ovf = 1'b0;
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int b = 0;
        while (rsp_id_q.size() < n && b < budget) begin tick(); b++; end
        check(name, rsp_id_q.size(), n);
    endtask

    initial begin
        int r0, h0;
        int exp2[5] = '{0, 1, 2, 3, 0};
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        fpa_done = 1'b0; fpa_result = '0; fpa_ovf = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_grant", grant_id, 0);

        // Single request: 1.5 + 1.5, adder latency 5.
        set_ops(0, 32'h3FC0_0000, 32'h3FC0_0000);
        add_lat = 5; rem[0] = 1;
        run_until(1, 40, "t1_wait");
        check("t1_ready", hs_rdy_q[0], 4'b0001);
        check("t1_start_lat", last_start - hs_cyc_q[0], 1);
        check("t1_rsp_lat", rsp_cyc_q[0] - hs_cyc_q[0], 7);
        check("t1_rsp_vec", rsp_vec_q[0], 4'b0001);
        check("t1_result", rsp_res_q[0], 32'h4040_0000);
        check("t1_ovf", rsp_ovf_q[0], 0);

        // Contention from reset: all four valid, requester 0 twice.
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 32'h4000_0000 + i, 32'h3F80_0000 + (i << 4));
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        add_lat = 3;
        r0 = rsp_id_q.size();
        run_until(r0 + 5, 120, "t2_wait");
        for (int k = 0; k < 5; k++) check($sformatf("t2_order%0d", k), rsp_id_q[r0 + k], exp2[k]);

        // Fairness after gap: req 2 alone, then 1 and 3 together.
        r0 = rsp_id_q.size();
        rem[2] = 1;
        run_until(r0 + 1, 40, "t3a_wait");
        rem[1] = 1; rem[3] = 1;
        run_until(r0 + 3, 80, "t3b_wait");
        check("t3_first", rsp_id_q[r0], 2);
        check("t3_second", rsp_id_q[r0 + 1], 3);
        check("t3_third", rsp_id_q[r0 + 2], 1);

        // Overflow passthrough, with a stray done during the start cycle.
        set_ops(2, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
        add_lat = 4; spur_cyc = cyc + 2; rem[2] = 1;
        r0 = rsp_id_q.size(); h0 = hs_cyc_q.size();
        run_until(r0 + 1, 40, "t4_wait");
        spur_cyc = -1;
        check("t4_id", rsp_id_q[r0], 2);
        check("t4_result", rsp_res_q[r0], 32'h7F80_0000);
        check("t4_ovf", rsp_ovf_q[r0], 1);
        check("t4_rsp_lat", rsp_cyc_q[r0] - hs_cyc_q[h0], 6);

        // Reset during WAIT: response dropped, late done ignored, pointer back to 0.
        set_ops(3, 32'h0000_1111, 32'h0000_2222);
        add_lat = 20; rem[3] = 1;
        r0 = rsp_id_q.size();
        repeat (6) tick();
        check("t5_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy_after", busy, 0);
        check("t5_grant_after", grant_id, 0);
        check("t5_fpa_a_after", fpa_a, 0);
        repeat (25) tick();
        check("t5_no_rsp", rsp_id_q.size(), r0);
        set_ops(0, 32'h3FC0_0000, 32'h3FC0_0000);
        add_lat = 2; rem[0] = 1; rem[3] = 1;
        run_until(r0 + 2, 60, "t5_wait");
        check("t5_first", rsp_id_q[r0], 0);
        check("t5_second", rsp_id_q[r0 + 1], 3);

`ifdef FPA_SCHED_TIMEOUT_EN
        // Adder never answers: abort after TIMEOUT wait cycles.
        add_hang = 1; rem[1] = 1;
        r0 = rsp_id_q.size();
        run_until(r0 + 1, 40, "t6_wait");
        add_hang = 0;
        check("t6_id", rsp_id_q[r0], 1);
        check("t6_lat", rsp_cyc_q[r0] - last_start, 9);
        check("t6_err", rsp_err_q[r0], 1);
        check("t6_result", rsp_res_q[r0], 0);
        check("t6_ovf", rsp_ovf_q[r0], 0);
        // Done on the timeout cycle wins.
        add_lat = TO; rem[2] = 1;
        run_until(r0 + 2, 40, "t6_tie_wait");
        check("t6_tie_lat", rsp_cyc_q[r0 + 1] - last_start, 9);
        check("t6_tie_err", rsp_err_q[r0 + 1], 0);
        check("t6_tie_result", rsp_res_q[r0 + 1], 32'h7F80_0000);
`endif

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
